// File: rtl/jstk_spi_responder_pkg.sv
// Shared constants, state encoding and TX frame packing for the PmodJSTK emulator.
package jstk_pkg;

  localparam logic [5:0]  JSTK_CMD_PREFIX = 6'b100000;
  localparam int unsigned JSTK_FRAME_BITS = 40;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } jstk_state_e;

  // Byte 0 leaves first, so it occupies the top of the shift register.
  function automatic logic [39:0] jstk_frame(input logic [9:0] x, input logic [9:0] y,
                                             input logic [2:0] b);
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
  endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// SPI pin bundle between the joystick master and the emulated PmodJSTK.
interface jstk_spi_responder_if;

  logic SCLK;
  logic SS;
  logic MOSI;
  logic MISO;

  modport master (
    output SCLK,
    output SS,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SCLK,
    input  SS,
    input  MOSI,
    output MISO
  );

endinterface

// File: rtl/jstk_spi_responder_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin plus a rise/fall edge detector.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2  // must be at least 2
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI slave emulating the PmodJSTK: returns an X/Y/button snapshot and decodes the LED command.
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  jstk_spi_responder_if.slave  spi,
  input  logic [9:0]           x_val,
  input  logic [9:0]           y_val,
  input  logic [2:0]           btn,
  output logic [1:0]           led_cmd,
  output logic                 cmd_valid,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [5:0] FrameBits = 6'(JSTK_FRAME_BITS);
  localparam logic [5:0] CmdLastBit = 6'd7;

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (clk),
    .clr   (clr),
    .din   (spi.SCLK),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk   (clk),
    .clr   (clr),
    .din   (spi.SS),
    .level (ss_level),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // MOSI shares the SCLK pipeline depth, so its level is aligned with sclk_rise.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .clr   (clr),
    .din   (spi.MOSI),
    .level (mosi_level),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_level, ss_level, mosi_rise, mosi_fall};

  jstk_state_e state_q, state_d;
  logic [39:0] tx_q, tx_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [1:0]  led_q, led_d;
  logic        miso_q, miso_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        frame_done_q, frame_done_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= IDLE;
      tx_q         <= '0;
      cnt_q        <= '0;
      rx_q         <= '0;
      led_q        <= 2'b00;
      miso_q       <= 1'b0;
      cmd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      cnt_q        <= cnt_d;
      rx_q         <= rx_d;
      led_q        <= led_d;
      miso_q       <= miso_d;
      cmd_valid_q  <= cmd_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    cnt_d        = cnt_q;
    rx_d         = rx_q;
    led_d        = led_q;
    miso_d       = miso_q;
    cmd_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          tx_d    = jstk_frame(x_val, y_val, btn);
          miso_d  = tx_d[39];
          cnt_d   = '0;
          rx_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // SS rise takes priority and swallows any coincident SCLK edge.
        if (ss_rise) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end else if (sclk_rise) begin
          rx_d  = {rx_q[6:0], mosi_level};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == CmdLastBit && rx_d[7:2] == JSTK_CMD_PREFIX) begin
            led_d       = rx_d[1:0];
            cmd_valid_d = 1'b1;
          end
          if (cnt_d == FrameBits) begin
            miso_d       = 1'b0;
            frame_done_d = 1'b1;
            state_d      = DONE;
          end
        end else if (sclk_fall) begin
          tx_d   = {tx_q[38:0], 1'b0};
          miso_d = tx_q[38];
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (ss_rise) begin
          state_d = IDLE;
        end
      end
      default: begin
        miso_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign spi.MISO   = miso_q;
  assign led_cmd    = led_q;
  assign cmd_valid  = cmd_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: table of full frames plus abort/overrun/reset sequences.
module tb_jstk_spi_responder;

  localparam int Half = 8;  // SCLK half period in clk cycles

  logic       clk;
  logic       clr;
  logic [9:0] x_val;
  logic [9:0] y_val;
  logic [2:0] btn;
  logic [1:0] led_cmd;
  logic       cmd_valid;
  logic       busy;
  logic       frame_done;

  jstk_spi_responder_if spi_if ();

  jstk_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .clr        (clr),
    .spi        (spi_if),
    .x_val      (x_val),
    .y_val      (y_val),
    .btn        (btn),
    .led_cmd    (led_cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cv_cnt   = 0;
  int fd_cnt   = 0;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) cv_cnt = cv_cnt + 1;
    if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
  end

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  b;
    logic [7:0]  cmd;
    logic [39:0] frame;
    logic [1:0]  led;
    int          cv;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic mo, output logic mi);
    spi_if.MOSI = mo;
    wait_clks(Half);
    mi = spi_if.MISO;
    spi_if.SCLK = 1'b1;
    wait_clks(Half);
    spi_if.SCLK = 1'b0;
  endtask

  task automatic ss_low();
    spi_if.SS = 1'b0;
    wait_clks(Half);
  endtask

  task automatic ss_high();
    wait_clks(Half);
    spi_if.SS = 1'b1;
    wait_clks(Half);
  endtask

  // Clocks nbits bits with cmd as the first MOSI byte; keeps SS low afterwards.
  task automatic shift_bits(input logic [7:0] cmd, input int nbits, output logic [47:0] rx);
    logic mi;
    logic mo;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mo = (i < 8) ? cmd[7-i] : 1'b0;
      spi_bit(mo, mi);
      rx = {rx[46:0], mi};
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, output logic [47:0] rx);
    ss_low();
    shift_bits(cmd, 40, rx);
    ss_high();
  endtask

  logic [47:0] rx;
  int          cv0;
  int          fd0;

  initial begin
    vecs[0] = '{x: 10'h2A5, y: 10'h13C, b: 3'b101, cmd: 8'h83,
                frame: 40'hA5_02_3C_01_05, led: 2'b11, cv: 1};
    vecs[1] = '{x: 10'h2A5, y: 10'h13C, b: 3'b101, cmd: 8'h82,
                frame: 40'hA5_02_3C_01_05, led: 2'b10, cv: 1};
    vecs[2] = '{x: 10'h155, y: 10'h2AA, b: 3'b010, cmd: 8'h42,
                frame: 40'h55_01_AA_02_02, led: 2'b10, cv: 0};
    vecs[3] = '{x: 10'h3FF, y: 10'h000, b: 3'b111, cmd: 8'h80,
                frame: 40'hFF_03_00_00_07, led: 2'b00, cv: 1};
    vecs[4] = '{x: 10'h0C3, y: 10'h300, b: 3'b000, cmd: 8'h81,
                frame: 40'hC3_00_00_03_00, led: 2'b01, cv: 1};

    clr         = 1'b0;
    spi_if.SS   = 1'b1;
    spi_if.SCLK = 1'b0;
    spi_if.MOSI = 1'b0;
    x_val       = 10'h2A5;
    y_val       = 10'h13C;
    btn         = 3'b101;
    wait_clks(3);

    check("reset_miso", 64'(spi_if.MISO), 64'(1'b0));
    check("reset_led", 64'(led_cmd), 64'(2'b00));
    check("reset_cmd_valid", 64'(cmd_valid), 64'(1'b0));
    check("reset_busy", 64'(busy), 64'(1'b0));
    check("reset_frame_done", 64'(frame_done), 64'(1'b0));
    clr = 1'b1;
    wait_clks(10);
    check("post_reset_busy", 64'(busy), 64'(1'b0));

    // Full frames with various snapshots and command bytes.
    for (int v = 0; v < 5; v++) begin
      x_val = vecs[v].x;
      y_val = vecs[v].y;
      btn   = vecs[v].b;
      cv0   = cv_cnt;
      fd0   = fd_cnt;
      run_frame(vecs[v].cmd, rx);
      check($sformatf("vec%0d_frame", v), 64'(rx[39:0]), 64'(vecs[v].frame));
      check($sformatf("vec%0d_led", v), 64'(led_cmd), 64'(vecs[v].led));
      check($sformatf("vec%0d_cmd_valid_pulses", v), 64'(cv_cnt - cv0), 64'(vecs[v].cv));
      check($sformatf("vec%0d_frame_done_pulses", v), 64'(fd_cnt - fd0), 64'(1));
      check($sformatf("vec%0d_busy_after", v), 64'(busy), 64'(1'b0));
    end

    // Snapshot is frozen at SS fall; mid-frame X change only shows up next frame.
    x_val = 10'h000;
    y_val = 10'h000;
    btn   = 3'b000;
    ss_low();
    shift_bits(8'h00, 24, rx);
    check("snap_first_bytes", 64'(rx[23:8]), 64'(16'h0000));
    x_val = 10'h3FF;
    shift_bits(8'h00, 16, rx);
    check("snap_tail_bytes", 64'(rx[15:0]), 64'(16'h0000));
    ss_high();
    run_frame(8'h00, rx);
    check("snap_next_frame", 64'(rx[39:0]), 64'(40'hFF_03_00_00_00));

    // Abort after 13 bits.
    x_val = 10'h2A5;
    y_val = 10'h13C;
    btn   = 3'b101;
    fd0   = fd_cnt;
    ss_low();
    shift_bits(8'h83, 13, rx);
    check("abort_busy_during", 64'(busy), 64'(1'b1));
    ss_high();
    check("abort_busy", 64'(busy), 64'(1'b0));
    check("abort_miso", 64'(spi_if.MISO), 64'(1'b0));
    check("abort_no_frame_done", 64'(fd_cnt - fd0), 64'(0));
    check("abort_led_accepted", 64'(led_cmd), 64'(2'b11));
    run_frame(8'h00, rx);
    check("after_abort_frame", 64'(rx[39:0]), 64'(40'hA5_02_3C_01_05));

    // 48 SCLK periods in one SS window.
    fd0 = fd_cnt;
    ss_low();
    shift_bits(8'h00, 48, rx);
    check("overrun_frame", 64'(rx[47:8]), 64'(40'hA5_02_3C_01_05));
    check("overrun_tail_zero", 64'(rx[7:0]), 64'(8'h00));
    check("overrun_frame_done", 64'(fd_cnt - fd0), 64'(1));
    check("overrun_busy_done", 64'(busy), 64'(1'b1));
    check("overrun_miso", 64'(spi_if.MISO), 64'(1'b0));
    ss_high();
    check("overrun_busy_after", 64'(busy), 64'(1'b0));

    // Reset mid-frame with a previously accepted command.
    run_frame(8'h82, rx);
    check("pre_clr_led", 64'(led_cmd), 64'(2'b10));
    fd0 = fd_cnt;
    ss_low();
    shift_bits(8'h00, 20, rx);
    clr = 1'b0;
    wait_clks(2);
    check("clr_miso", 64'(spi_if.MISO), 64'(1'b0));
    check("clr_led", 64'(led_cmd), 64'(2'b00));
    check("clr_busy", 64'(busy), 64'(1'b0));
    check("clr_cmd_valid", 64'(cmd_valid), 64'(1'b0));
    check("clr_frame_done", 64'(frame_done), 64'(1'b0));
    clr = 1'b1;
    wait_clks(4);
    // SS is still low: no fresh falling edge, so no frame may start.
    shift_bits(8'h00, 20, rx);
    check("clr_no_restart_busy", 64'(busy), 64'(1'b0));
    check("clr_no_restart_miso", 64'(rx[19:0]), 64'(20'h00000));
    check("clr_no_frame_done", 64'(fd_cnt - fd0), 64'(0));
    ss_high();
    run_frame(8'h81, rx);
    check("after_clr_frame", 64'(rx[39:0]), 64'(40'hA5_02_3C_01_05));
    check("after_clr_led", 64'(led_cmd), 64'(2'b01));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
